// File: rtl/riscv_pkg.sv
// Shared RV64 decode constants and MUL stall FSM types.
// Imported by the EX-stage multiply unit and its datapath.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

  function automatic logic is_mul(input logic [31:0] inst);
    return (inst[6:0] == OP_REG) &&
           (inst[31:25] == F7_MULDIV) &&
           (inst[14:12] == F3_MUL);
  endfunction

endpackage

// File: rtl/mul_iter_datapath.sv
// Iterative shift-add multiplier datapath: B multiplier bits per step.
// Holds acc, mcand, mplier and the iteration counter.
module mul_iter_datapath
  import riscv_pkg::*;
#(
  parameter int B = 1,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] mcand_i,
  input  logic [W-1:0] mplier_i,
  output logic [W-1:0] acc_nxt_o,
  output logic         last_o
);

  localparam int N  = W / B;
  localparam int CW = $clog2(N);

  logic [W-1:0]  acc_q, mcand_q, mplier_q;
  logic [W-1:0]  part;
  logic [CW-1:0] cnt_q;

  always_comb begin
    part = '0;
    for (int i = 0; i < B; i++) begin
      if (mplier_q[i]) part = part + (mcand_q << i);
    end
    acc_nxt_o = acc_q + part;
  end

  assign last_o = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_nxt_o;
      mcand_q  <= mcand_q << B;
      mplier_q <= mplier_q >> B;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mul_stall_unit.sv
// EX-stage RV64 MUL unit: iterative multiply with upstream stall.
// Non-MUL instructions pass without stalling.
module ex_mul_stall_unit
  import riscv_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [31:0]     ex_inst,
  input  logic [XLEN-1:0] ex_res1,
  input  logic [XLEN-1:0] ex_res2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_regwrite,
  input  logic            flush,
  output logic            stall,
  output logic            mul_done,
  output logic [XLEN-1:0] mul_result,
  output logic [4:0]      mul_rd,
  output logic            mul_regwrite,
  output logic            busy
);

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            start, load, step, last;
  logic [XLEN-1:0] acc_nxt;

  mul_iter_datapath #(
    .B (BITS_PER_CYCLE),
    .W (XLEN)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .step_i    (step),
    .mcand_i   (ex_res1),
    .mplier_i  (ex_res2),
    .acc_nxt_o (acc_nxt),
    .last_o    (last)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    load     = 1'b0;
    step     = 1'b0;
    stall    = 1'b0;
    start    = ex_valid & is_mul(ex_inst) &
               ~flush & (state_q == IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load  = 1'b1;
          stall = 1'b1;
          rd_d  = ex_rd;
          rw_d  = ex_regwrite;
          if ((ex_res1 == '0) || (ex_res2 == '0)) begin
            state_d  = DONE;
            result_d = '0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A kill in BUSY releases the pipeline this very cycle.
        if (flush) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          step  = 1'b1;
          if (last) begin
            state_d  = DONE;
            result_d = acc_nxt;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
    end
  end

  assign mul_done     = (state_q == DONE);
  assign mul_result   = result_q;
  assign mul_rd       = rd_q;
  assign mul_regwrite = mul_done & rw_q & (|rd_q) & ~flush;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ex_mul_stall_unit.sv
// Scoreboard bench for ex_mul_stall_unit, B=1 and B=4 instances.
// Stimulus pushes expected results; a monitor pops on mul_done.
`timescale 1ns/1ps
module tb_ex_mul_stall_unit;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid[2], ex_regwrite[2], flush[2];
  logic [31:0] ex_inst[2];
  logic [63:0] ex_res1[2], ex_res2[2];
  logic [4:0]  ex_rd[2];
  logic        stall[2], mul_done[2], mul_regwrite[2], busy[2];
  logic [63:0] mul_result[2];
  logic [4:0]  mul_rd[2];

  exp_t q0[$];
  exp_t q1[$];
  int   ncmp = 0;
  int   nerr = 0;

  localparam logic [31:0] MUL = 32'h0220_83B3;
  localparam logic [31:0] ADD = 32'h0020_83B3;

  always #5 clk = ~clk;

  ex_mul_stall_unit #(.BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid[0]), .ex_inst(ex_inst[0]),
    .ex_res1(ex_res1[0]), .ex_res2(ex_res2[0]),
    .ex_rd(ex_rd[0]), .ex_regwrite(ex_regwrite[0]),
    .flush(flush[0]), .stall(stall[0]),
    .mul_done(mul_done[0]), .mul_result(mul_result[0]),
    .mul_rd(mul_rd[0]), .mul_regwrite(mul_regwrite[0]),
    .busy(busy[0])
  );

  ex_mul_stall_unit #(.BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid[1]), .ex_inst(ex_inst[1]),
    .ex_res1(ex_res1[1]), .ex_res2(ex_res2[1]),
    .ex_rd(ex_rd[1]), .ex_regwrite(ex_regwrite[1]),
    .flush(flush[1]), .stall(stall[1]),
    .mul_done(mul_done[1]), .mul_result(mul_result[1]),
    .mul_rd(mul_rd[1]), .mul_regwrite(mul_regwrite[1]),
    .busy(busy[1])
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int k, input exp_t e);
    chk($sformatf("u%0d result", k), mul_result[k], e.res);
    chk($sformatf("u%0d rd", k), 64'(mul_rd[k]), 64'(e.rd));
    chk($sformatf("u%0d regwrite", k),
        64'(mul_regwrite[k]), 64'(e.rw));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mul_done[0] === 1'b1) begin
        if (q0.size() == 0) chk("u0 unexpected done", 1, 0);
        else mon(0, q0.pop_front());
      end
      if (mul_done[1] === 1'b1) begin
        if (q1.size() == 0) chk("u1 unexpected done", 1, 0);
        else mon(1, q1.pop_front());
      end
    end
  end

  // Caller sits at posedge+1; returns at posedge+1 after ID/EX advanced.
  task automatic issue(input int k, input logic [31:0] inst,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic rw,
                       input logic [63:0] exp_res,
                       input int exp_stall);
    int  cnt;
    bit  fin;
    bit  m;
    exp_t e;
    m = (inst == MUL);
    if (m) begin
      e.res = exp_res;
      e.rd  = rd;
      e.rw  = rw && (rd != 0);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    ex_valid[k] = 1'b1;
    ex_inst[k] = inst;
    ex_res1[k] = a;
    ex_res2[k] = b;
    ex_rd[k] = rd;
    ex_regwrite[k] = rw;
    cnt = 0;
    fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (stall[k]) cnt++;
      else begin
        fin = 1;
        chk("done after stall", 64'(mul_done[k]), 64'(m));
      end
      @(posedge clk);
      #1;
    end
    if (!fin) chk("stall timeout", 0, 1);
    chk($sformatf("stall cycles u%0d", k), 64'(cnt), 64'(exp_stall));
    ex_valid[k] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ex_valid[k] = 0; ex_inst[k] = 0; ex_res1[k] = 0;
      ex_res2[k] = 0; ex_rd[k] = 0; ex_regwrite[k] = 0;
      flush[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst done", 64'(mul_done[0]), 0);
    chk("rst busy", 64'(busy[0]), 0);
    chk("rst result", mul_result[0], 0);
    chk("rst stall", 64'(stall[0]), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, MUL, 64'd3, 64'd5, 5'd7, 1, 64'd15, 65);
    issue(0, MUL, 64'hFFFF_FFFF_FFFF_FFFE, 64'd7, 5'd1, 1,
          64'hFFFF_FFFF_FFFF_FFF2, 65);
    issue(0, MUL, 64'h1_0000_0000, 64'h1_0000_0000, 5'd2, 1,
          64'd0, 65);
    issue(0, MUL, 64'd99, 64'd0, 5'd3, 1, 64'd0, 1);
    issue(0, ADD, 64'd4, 64'd5, 5'd3, 1, 64'd0, 0);
    issue(0, MUL, 64'd11, 64'd13, 5'd8, 0, 64'd143, 65);

    // Flush in BUSY cycle 10: no done, pipeline released at once.
    ex_valid[0] = 1; ex_inst[0] = MUL; ex_res1[0] = 9;
    ex_res2[0] = 9; ex_rd[0] = 6; ex_regwrite[0] = 1;
    @(negedge clk);
    chk("flush start stall", 64'(stall[0]), 1);
    @(posedge clk);
    #1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush[0] = 1;
    @(negedge clk);
    chk("flush stall", 64'(stall[0]), 0);
    chk("flush busy before", 64'(busy[0]), 1);
    @(posedge clk);
    #1;
    flush[0] = 0;
    ex_valid[0] = 0;
    @(negedge clk);
    chk("flush idle", 64'(busy[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    issue(0, MUL, 64'd6, 64'd7, 5'd9, 1, 64'd42, 65);

    // Async reset mid-BUSY.
    ex_valid[0] = 1; ex_inst[0] = MUL; ex_res1[0] = 5;
    ex_res2[0] = 5; ex_rd[0] = 4; ex_regwrite[0] = 1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("pre-reset busy", 64'(busy[0]), 1);
    #2;
    rst_n = 1'b0;
    ex_valid[0] = 0;
    #1;
    chk("arst busy", 64'(busy[0]), 0);
    chk("arst stall", 64'(stall[0]), 0);
    chk("arst result", mul_result[0], 0);
    chk("arst rd", 64'(mul_rd[0]), 0);
    chk("arst done", 64'(mul_done[0]), 0);
    chk("arst regwrite", 64'(mul_regwrite[0]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, MUL, 64'd3, 64'd5, 5'd0, 1, 64'd15, 65);

    // Back-to-back on the 4-bit/cycle instance.
    issue(1, MUL, 64'd2, 64'd3, 5'd4, 1, 64'd6, 17);
    issue(1, MUL, 64'd4, 64'd5, 5'd5, 1, 64'd20, 17);
    issue(1, MUL, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1, 64'd1, 17);

    repeat (5) @(posedge clk);
    #1;
    chk("q0 drained", 64'(q0.size()), 0);
    chk("q1 drained", 64'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
